// File: rtl/design_sel_strap.sv
// ---------------------------------------------------------------------------
// design_sel_strap
//
// Boot-time design selector and reset sequencer for the multi-design pad
// multiplexer. Five asynchronous strap pads are synchronized and debounced.
// Once they have been stable for STABLE_CYCLES samples, the value is latched
// onto design_sel. The selected design is then held in reset for
// RELEASE_DELAY cycles, after which the shared design reset is released.
//
// Optional feature macro: SEL_RELOAD_EN
//   defined   : a reload_req_i pulse seen in RUN re-enters SAMPLE. The design
//               is put back in reset and the straps are selected again.
//               reload_ack_o pulses for the first SAMPLE cycle.
//   undefined : reload_req_i is ignored and reload_ack_o is tied low.
//               RUN is terminal until rst_n is asserted.
//
// Ports
//   clk_i         in   1  single clock
//   rst_n         in   1  synchronous active-low reset
//   strap_i       in   5  raw strap pads, asynchronous to clk_i
//   reload_req_i  in   1  runtime reselect request (SEL_RELOAD_EN only)
//   design_sel    out  5  latched design selection, 5'h1F while parked
//   sel_valid     out  1  high once design_sel is latched
//   design_rst_n  out  1  active-low reset to all designs
//   reload_ack_o  out  1  one-cycle pulse when a reload is accepted
//   state_o       out  2  FSM state: SAMPLE=0, LATCH=1, HOLD=2, RUN=3
//
// Reload handshake: reload_req_i is a level sampled on each clk_i edge. It
// is consumed only while the FSM is in RUN. One sampled high edge is a
// complete request. reload_ack_o is high for exactly the cycle after the
// accepting edge. Requests seen in any other state are dropped, not queued.
// ---------------------------------------------------------------------------
module design_sel_strap #(
    parameter int STABLE_CYCLES = 1024,
    parameter int RELEASE_DELAY = 16
) (
    input  logic       clk_i,
    input  logic       rst_n,
    input  logic [4:0] strap_i,
    input  logic       reload_req_i,
    output logic [4:0] design_sel,
    output logic       sel_valid,
    output logic       design_rst_n,
    output logic       reload_ack_o,
    output logic [1:0] state_o
);

    localparam int CNT_W = $clog2(STABLE_CYCLES);
    localparam int REL_W = $clog2(RELEASE_DELAY + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [REL_W-1:0] REL_LAST = REL_W'(RELEASE_DELAY - 1);
    localparam logic [4:0]       PARK_SEL = 5'h1F;

    typedef enum logic [1:0] {
        SAMPLE = 2'd0,
        LATCH  = 2'd1,
        HOLD   = 2'd2,
        RUN    = 2'd3
    } state_t;

    logic [4:0]       sync1_q, sync1_d;
    logic [4:0]       s_sync_q, s_sync_d;
    logic [4:0]       s_prev_q, s_prev_d;
    logic [CNT_W-1:0] stab_cnt_q, stab_cnt_d;
    logic [REL_W-1:0] rel_cnt_q, rel_cnt_d;
    state_t           state_q, state_d;
    logic [4:0]       design_sel_q, design_sel_d;
    logic             sel_valid_q, sel_valid_d;
    logic             design_rst_n_q, design_rst_n_d;
    logic             reload_ack_q, reload_ack_d;

`ifndef SEL_RELOAD_EN
    // The port stays on the boundary so both builds share one pinout.
    logic reload_unused;
    assign reload_unused = reload_req_i;
`endif

    always_comb begin
        sync1_d  = strap_i;
        s_sync_d = sync1_q;
        s_prev_d = s_sync_q;

        // Any difference restarts the stability window. Saturate so that a
        // long stable run never wraps back into a false "unstable" count.
        if (s_sync_q != s_prev_q) begin
            stab_cnt_d = '0;
        end else if (stab_cnt_q == CNT_MAX) begin
            stab_cnt_d = stab_cnt_q;
        end else begin
            stab_cnt_d = stab_cnt_q + 1'b1;
        end

        rel_cnt_d      = rel_cnt_q;
        state_d        = state_q;
        design_sel_d   = design_sel_q;
        sel_valid_d    = sel_valid_q;
        design_rst_n_d = design_rst_n_q;
        reload_ack_d   = 1'b0;

        case (state_q)
            SAMPLE: begin
                // Leave as soon as this edge brings the counter to its
                // terminal value. A change on the same edge yields 0 here,
                // so the window restarts.
                if (stab_cnt_d == CNT_MAX) begin
                    state_d = LATCH;
                end
            end
            LATCH: begin
                // design_sel and sel_valid move together on HOLD entry.
                design_sel_d = s_sync_q;
                sel_valid_d  = 1'b1;
                rel_cnt_d    = '0;
                state_d      = HOLD;
            end
            HOLD: begin
                if (rel_cnt_q == REL_LAST) begin
                    design_rst_n_d = 1'b1;
                    state_d        = RUN;
                end else begin
                    rel_cnt_d = rel_cnt_q + 1'b1;
                end
            end
            RUN: begin
`ifdef SEL_RELOAD_EN
                // Reset, valid and selection change on a single edge. No
                // design ever runs with the parking code.
                if (reload_req_i) begin
                    design_rst_n_d = 1'b0;
                    sel_valid_d    = 1'b0;
                    design_sel_d   = PARK_SEL;
                    reload_ack_d   = 1'b1;
                    stab_cnt_d     = '0;
                    rel_cnt_d      = '0;
                    state_d        = SAMPLE;
                end
`endif
            end
            default: begin
                state_d = SAMPLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            sync1_q        <= 5'h00;
            s_sync_q       <= 5'h00;
            s_prev_q       <= 5'h00;
            stab_cnt_q     <= '0;
            rel_cnt_q      <= '0;
            state_q        <= SAMPLE;
            design_sel_q   <= PARK_SEL;
            sel_valid_q    <= 1'b0;
            design_rst_n_q <= 1'b0;
            reload_ack_q   <= 1'b0;
        end else begin
            sync1_q        <= sync1_d;
            s_sync_q       <= s_sync_d;
            s_prev_q       <= s_prev_d;
            stab_cnt_q     <= stab_cnt_d;
            rel_cnt_q      <= rel_cnt_d;
            state_q        <= state_d;
            design_sel_q   <= design_sel_d;
            sel_valid_q    <= sel_valid_d;
            design_rst_n_q <= design_rst_n_d;
            reload_ack_q   <= reload_ack_d;
        end
    end

    assign design_sel   = design_sel_q;
    assign sel_valid    = sel_valid_q;
    assign design_rst_n = design_rst_n_q;
    assign reload_ack_o = reload_ack_q;
    assign state_o      = state_q;

endmodule

// File: tb/tb_design_sel_strap.sv
// ---------------------------------------------------------------------------
// tb_design_sel_strap
//
// Directed bench for design_sel_strap with STABLE_CYCLES=8 and
// RELEASE_DELAY=4. Each step pushes the expected output vector
// {state_o, reload_ack_o, design_rst_n, sel_valid, design_sel} to exp_q.
// The step then advances one edge, samples the outputs 1 ns later, and pops
// and compares. Inputs change only just after a sampled edge.
// ---------------------------------------------------------------------------
module tb_design_sel_strap;

    localparam int STABLE_CYCLES = 8;
    localparam int RELEASE_DELAY = 4;
    localparam int W = 10;

    localparam logic [1:0] ST_SAMPLE = 2'd0;
    localparam logic [1:0] ST_LATCH  = 2'd1;
    localparam logic [1:0] ST_HOLD   = 2'd2;
    localparam logic [1:0] ST_RUN    = 2'd3;

    // ---------------- clock / reset ----------------
    logic       clk_i = 1'b0;
    logic       rst_n;
    logic [4:0] strap_i;
    logic       reload_req_i;
    logic [4:0] design_sel;
    logic       sel_valid;
    logic       design_rst_n;
    logic       reload_ack_o;
    logic [1:0] state_o;

    always #5 clk_i = ~clk_i;

    design_sel_strap #(
        .STABLE_CYCLES(STABLE_CYCLES),
        .RELEASE_DELAY(RELEASE_DELAY)
    ) dut (
        .clk_i        (clk_i),
        .rst_n        (rst_n),
        .strap_i      (strap_i),
        .reload_req_i (reload_req_i),
        .design_sel   (design_sel),
        .sel_valid    (sel_valid),
        .design_rst_n (design_rst_n),
        .reload_ack_o (reload_ack_o),
        .state_o      (state_o)
    );

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    int n_pass  = 0;
    int n_total = 0;

    function automatic logic [W-1:0] pk(input logic [1:0] st, input logic ack,
                                        input logic rstn, input logic valid,
                                        input logic [4:0] sel);
        return {st, ack, rstn, valid, sel};
    endfunction

    function automatic logic [W-1:0] park();
        return pk(ST_SAMPLE, 1'b0, 1'b0, 1'b0, 5'h1F);
    endfunction

    // ---------------- driver tasks ----------------
    task automatic step(input string tag, input logic [W-1:0] exp);
        logic [W-1:0] want;
        logic [W-1:0] got;
        exp_q.push_back(exp);
        @(posedge clk_i);
        #1;
        want = exp_q.pop_front();
        got  = {state_o, reload_ack_o, design_rst_n, sel_valid, design_sel};
        n_total++;
        assert (got === want) n_pass++;
        else $error("FAIL %s: got st=%0d ack=%b rstn=%b valid=%b sel=%b, expected st=%0d ack=%b rstn=%b valid=%b sel=%b",
                    tag, got[9:8], got[7], got[6], got[5], got[4:0],
                    want[9:8], want[7], want[6], want[5], want[4:0]);
    endtask

    // n_sample SAMPLE edges, one LATCH edge, RELEASE_DELAY HOLD edges, then
    // three RUN edges. Straps change mid-HOLD and mid-RUN. An optional
    // reload request is pulsed mid-HOLD; both must have no effect.
    task automatic expect_boot(input string tag, input int n_sample,
                               input logic [4:0] sel,
                               input logic [4:0] strap_hold,
                               input logic [4:0] strap_run,
                               input logic req_hold);
        for (int i = 0; i < n_sample; i++) step({tag, "_sample"}, park());
        step({tag, "_latch"}, pk(ST_LATCH, 1'b0, 1'b0, 1'b0, 5'h1F));
        for (int i = 0; i < RELEASE_DELAY; i++) begin
            if (i == 1) begin
                strap_i      = strap_hold;
                reload_req_i = req_hold;
            end
            if (i == 2) reload_req_i = 1'b0;
            step({tag, "_hold"}, pk(ST_HOLD, 1'b0, 1'b0, 1'b1, sel));
        end
        for (int i = 0; i < 3; i++) begin
            if (i == 1) strap_i = strap_run;
            step({tag, "_run"}, pk(ST_RUN, 1'b0, 1'b1, 1'b1, sel));
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n        = 1'b0;
        strap_i      = 5'b11010;
        reload_req_i = 1'b0;

        // Reset state.
        step("reset0", park());
        step("reset1", park());

        // 1. Constant straps: sel_valid at edge 11, design_rst_n at edge 15.
        rst_n = 1'b1;
        expect_boot("const", 9, 5'b11010, 5'b11010, 5'b11010, 1'b0);

        // 2 + 3. Bounce for 40 cycles, then settle on 11100. The straps are
        // then disturbed during HOLD and RUN.
        rst_n = 1'b0;
        step("rst_bounce", park());
        rst_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            strap_i = 5'b11100 | 5'((i / 3) % 2);
            step("bounce", park());
        end
        strap_i = 5'b11100;
        expect_boot("settle", 9, 5'b11100, 5'b00101, 5'b01010, 1'b0);

        // 4. One-cycle reset during HOLD, then a full sequence again. The
        // second boot also pulses reload_req_i during HOLD, which is dropped.
        rst_n   = 1'b0;
        strap_i = 5'b01100;
        step("rst_mid", park());
        rst_n = 1'b1;
        for (int i = 0; i < 9; i++) step("pre_abort_sample", park());
        step("pre_abort_latch", pk(ST_LATCH, 1'b0, 1'b0, 1'b0, 5'h1F));
        step("pre_abort_hold0", pk(ST_HOLD, 1'b0, 1'b0, 1'b1, 5'b01100));
        step("pre_abort_hold1", pk(ST_HOLD, 1'b0, 1'b0, 1'b1, 5'b01100));
        rst_n = 1'b0;
        step("abort_in_hold", park());
        rst_n = 1'b1;
        expect_boot("reboot", 9, 5'b01100, 5'b01100, 5'b01100, 1'b1);

`ifdef SEL_RELOAD_EN
        // 5. Reload from RUN with new straps: ack for one cycle, then a new
        // selection with sel_valid 9 cycles after the ack edge.
        strap_i = 5'b10000;
        step("pre_reload", pk(ST_RUN, 1'b0, 1'b1, 1'b1, 5'b01100));
        reload_req_i = 1'b1;
        step("reload_ack", pk(ST_SAMPLE, 1'b1, 1'b0, 1'b0, 5'h1F));
        reload_req_i = 1'b0;
        expect_boot("reload", 7, 5'b10000, 5'b10000, 5'b10000, 1'b0);
`else
        // 6. Reload disabled: a pulse in RUN changes nothing.
        strap_i      = 5'b10000;
        reload_req_i = 1'b1;
        step("no_reload", pk(ST_RUN, 1'b0, 1'b1, 1'b1, 5'b01100));
        reload_req_i = 1'b0;
        for (int i = 0; i < 12; i++)
            step("no_reload_after", pk(ST_RUN, 1'b0, 1'b1, 1'b1, 5'b01100));
`endif

        // ---------------- report ----------------
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // Watchdog for a stuck run.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks done", n_pass, n_total);
        $fatal(1, "watchdog");
    end

endmodule
